// File: rtl/regbank_wb_arbiter_pkg.sv
// Shared constants and types for the register-bank writeback path.
// The register bank uses the same widths and halt register index.
package regbank_wb_arbiter_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int HALT_REG = 30;
    localparam int CNT_W    = 16;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } wb_state_e;

    localparam logic GRANT_A = 1'b0;
    localparam logic GRANT_B = 1'b1;

endpackage

// File: rtl/regbank_wb_arbiter_rr_arb2.sv
// Two-input round-robin arbiter. gnt[0] is requester A and gnt[1] is requester B.
// On a tie, the requester that was not granted last wins.
module regbank_wb_arbiter_rr_arb2
    import regbank_wb_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_grant_q;
    logic last_grant_d;
    logic [1:0] gnt_s;

    // Grant selection and last-grant tracking
    always_comb begin
        gnt_s        = 2'b00;
        last_grant_d = last_grant_q;
        if (en) begin
            case (req)
                2'b01:   gnt_s = 2'b01;
                2'b10:   gnt_s = 2'b10;
                2'b11:   gnt_s = (last_grant_q == GRANT_A) ? 2'b10 : 2'b01;
                default: gnt_s = 2'b00;
            endcase
        end else begin
            gnt_s = 2'b00;
        end
        if (gnt_s[0]) begin
            last_grant_d = GRANT_A;
        end else if (gnt_s[1]) begin
            last_grant_d = GRANT_B;
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // B is reset as the last grant so that A wins the first tie
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= GRANT_B;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign gnt = gnt_s;

endmodule

// File: rtl/regbank_wb_arbiter.sv
// Shares the register bank write port between ALU (A) and load (B) writeback.
// It issues a one-cycle RegWrite per accepted write and stops granting after a program-done write.
module regbank_wb_arbiter #(
    parameter int DATA_W   = regbank_wb_arbiter_pkg::DATA_W,
    parameter int ADDR_W   = regbank_wb_arbiter_pkg::ADDR_W,
    parameter int HALT_REG = regbank_wb_arbiter_pkg::HALT_REG,
    parameter int CNT_W    = regbank_wb_arbiter_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    input  logic              halt_clr,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] write_register,
    output logic [DATA_W-1:0] write_data,
    output logic              halted,
    output logic [CNT_W-1:0]  wr_count
);

    import regbank_wb_arbiter_pkg::*;

    localparam logic [ADDR_W-1:0] HALT_ADDR = ADDR_W'(HALT_REG);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    wb_state_e         state_q;
    wb_state_e         state_d;
    logic [1:0]        gnt_s;
    logic              grant_en_s;
    logic              accept_s;
    logic              halt_hit_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_data_s;

    logic              reg_write_q;
    logic              reg_write_d;
    logic [ADDR_W-1:0] write_register_q;
    logic [ADDR_W-1:0] write_register_d;
    logic [DATA_W-1:0] write_data_q;
    logic [DATA_W-1:0] write_data_d;
    logic [CNT_W-1:0]  wr_count_q;
    logic [CNT_W-1:0]  wr_count_d;

    regbank_wb_arbiter_rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .en    (grant_en_s),
        .req   ({b_valid, a_valid}),
        .gnt   (gnt_s)
    );

    assign a_ready    = gnt_s[0];
    assign b_ready    = gnt_s[1];
    assign accept_s   = |gnt_s;
    assign sel_addr_s = gnt_s[1] ? b_addr : a_addr;
    assign sel_data_s = gnt_s[1] ? b_data : a_data;
    assign halt_hit_s = accept_s && (sel_addr_s == HALT_ADDR) && sel_data_s[0];

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; halt_clr is ignored in RUN, so halt entry wins over a coincident clear
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    state_d = halt_hit_s ? ST_HALTED : ST_RUN;
            ST_HALTED: state_d = halt_clr ? ST_RUN : ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
    end

    // FSM outputs
    always_comb begin
        grant_en_s = 1'b0;
        halted     = 1'b0;
        case (state_q)
            ST_RUN: begin
                grant_en_s = 1'b1;
                halted     = 1'b0;
            end
            ST_HALTED: begin
                grant_en_s = 1'b0;
                halted     = 1'b1;
            end
            default: begin
                grant_en_s = 1'b0;
                halted     = 1'b0;
            end
        endcase
    end

    // Write-port staging and saturating commit counter
    always_comb begin
        reg_write_d      = accept_s;
        write_register_d = write_register_q;
        write_data_d     = write_data_q;
        wr_count_d       = wr_count_q;
        if (accept_s) begin
            write_register_d = sel_addr_s;
            write_data_d     = sel_data_s;
            if (wr_count_q != CNT_MAX) begin
                wr_count_d = wr_count_q + CNT_W'(1);
            end else begin
                wr_count_d = wr_count_q;
            end
        end else begin
            write_register_d = write_register_q;
            write_data_d     = write_data_q;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_write_q      <= 1'b0;
            write_register_q <= {ADDR_W{1'b0}};
            write_data_q     <= {DATA_W{1'b0}};
            wr_count_q       <= {CNT_W{1'b0}};
        end else begin
            reg_write_q      <= reg_write_d;
            write_register_q <= write_register_d;
            write_data_q     <= write_data_d;
            wr_count_q       <= wr_count_d;
        end
    end

    assign RegWrite       = reg_write_q;
    assign write_register = write_register_q;
    assign write_data     = write_data_q;
    assign wr_count       = wr_count_q;

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Scoreboard bench for regbank_wb_arbiter.
// Accepted writes are queued when readies are checked and retired on each RegWrite pulse.
module tb_regbank_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [4:0]  a_addr = 5'd0;
    logic [31:0] a_data = 32'd0;
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [4:0]  b_addr = 5'd0;
    logic [31:0] b_data = 32'd0;
    logic        halt_clr = 1'b0;
    logic        RegWrite;
    logic [4:0]  write_register;
    logic [31:0] write_data;
    logic        halted;
    logic [15:0] wr_count;

    int          total = 0;
    int          bad = 0;
    logic [36:0] sb_q[$];
    logic [36:0] exp_w;

    regbank_wb_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .a_valid        (a_valid),
        .a_ready        (a_ready),
        .a_addr         (a_addr),
        .a_data         (a_data),
        .b_valid        (b_valid),
        .b_ready        (b_ready),
        .b_addr         (b_addr),
        .b_data         (b_data),
        .halt_clr       (halt_clr),
        .RegWrite       (RegWrite),
        .write_register (write_register),
        .write_data     (write_data),
        .halted         (halted),
        .wr_count       (wr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Retire one scoreboard entry per RegWrite pulse
    always @(negedge clk) begin
        if (!reset && RegWrite) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_write", 64'(RegWrite), 64'd0);
            end else begin
                exp_w = sb_q.pop_front();
                chk("wb_addr", 64'(write_register), 64'(exp_w[36:32]));
                chk("wb_data", 64'(write_data), 64'(exp_w[31:0]));
            end
        end
    end

    // Drive one cycle starting just after a rising edge, check readies and end just after the next edge
    task automatic step(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                        input logic ea, input logic eb);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        #1;
        chk("a_ready", 64'(a_ready), 64'(ea));
        chk("b_ready", 64'(b_ready), 64'(eb));
        if (ea) sb_q.push_back({aa, ad});
        if (eb) sb_q.push_back({ba, bd});
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1;
        chk("rst_regwrite", 64'(RegWrite), 64'd0);
        chk("rst_wreg", 64'(write_register), 64'd0);
        chk("rst_wdata", 64'(write_data), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_count", 64'(wr_count), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single A write after reset
        step(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        chk("t1_regwrite", 64'(RegWrite), 64'd1);
        chk("t1_wreg", 64'(write_register), 64'd5);
        chk("t1_count", 64'(wr_count), 64'd1);
        idle();
        chk("t1_pulse_end", 64'(RegWrite), 64'd0);
        chk("t1_hold_wreg", 64'(write_register), 64'd5);
        chk("t1_hold_wdata", 64'(write_data), 64'h1234);

        // Fresh reset, then both valid for four cycles: A,B,A,B back to back
        reset = 1'b1;
        #1;
        reset = 1'b0;
        sb_q.delete();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 5'd3, 32'hA, 1'b1, 5'd4, 32'hB, (i % 2) == 0, (i % 2) == 1);
            chk("t2_regwrite", 64'(RegWrite), 64'd1);
        end
        idle();
        chk("t2_count", 64'(wr_count), 64'd4);

        // Same-address conflict after an A grant: B commits first, A last
        step(1'b1, 5'd1, 32'h99, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        step(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22, 1'b0, 1'b1);
        step(1'b1, 5'd7, 32'h11, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        chk("t3_final_data", 64'(write_data), 64'h11);
        idle();

        // B write so the next tie goes to A, then halt on r30 while B waits
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'h77, 1'b0, 1'b1);
        halt_clr = 1'b1;
        step(1'b1, 5'd30, 32'h1, 1'b1, 5'd9, 32'h55, 1'b1, 1'b0);
        halt_clr = 1'b0;
        chk("t4_halted", 64'(halted), 64'd1);
        chk("t4_regwrite", 64'(RegWrite), 64'd1);
        chk("t4_wreg", 64'(write_register), 64'd30);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h55, 1'b0, 1'b0);
            chk("t4_still_halted", 64'(halted), 64'd1);
        end
        halt_clr = 1'b1;
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h55, 1'b0, 1'b0);
        halt_clr = 1'b0;
        chk("t4_cleared", 64'(halted), 64'd0);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h55, 1'b0, 1'b1);
        idle();

        // Asynchronous reset right after an acceptance drops the pending pulse
        step(1'b1, 5'd12, 32'hCAFE, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        chk("t5_pre_regwrite", 64'(RegWrite), 64'd1);
        a_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("t5_regwrite", 64'(RegWrite), 64'd0);
        chk("t5_halted", 64'(halted), 64'd0);
        chk("t5_count", 64'(wr_count), 64'd0);
        chk("t5_wreg", 64'(write_register), 64'd0);
        chk("t5_wdata", 64'(write_data), 64'd0);
        sb_q.delete();
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("t5_no_glitch", 64'(RegWrite), 64'd0);
        step(1'b1, 5'd0, 32'h5A, 1'b1, 5'd0, 32'hA5, 1'b1, 1'b0);
        chk("t5_r0_wreg", 64'(write_register), 64'd0);
        idle();

        // Counter saturation over 0xFFFF+2 back-to-back acceptances
        reset = 1'b1;
        #1;
        reset = 1'b0;
        sb_q.delete();
        @(posedge clk);
        #1;
        for (int i = 0; i < 65537; i++) begin
            step(1'b1, 5'd3, 32'(i), 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        end
        chk("t6_saturated", 64'(wr_count), 64'hFFFF);
        idle();
        idle();
        chk("t6_saturated_hold", 64'(wr_count), 64'hFFFF);
        chk("sb_drain", 64'(sb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regbank_wb_arbiter.md
Name: regbank_wb_arbiter

Overview:
- Shares the register bank's single write port between two writeback requesters: A = ALU result, B = memory load result.
- Round-robin arbitration; accepted writes are registered and presented to the bank as a one-cycle RegWrite pulse.
- Detects the program-done write (bit 0 of r30 set), then halts further writeback until cleared.
- Counts committed writes for debug and performance monitoring.

Parameters:
- DATA_W, 32, write data width.
- ADDR_W, 5, register address width.
- HALT_REG, 30, register whose bit 0 signals program completion.
- CNT_W, 16, width of the committed-write counter.

Ports:
- clk  in  1  single system clock, all state on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- a_valid  in  1  requester A has a write pending.
- a_ready  out  1  A's write is accepted this cycle.
- a_addr  in  ADDR_W  A destination register.
- a_data  in  DATA_W  A write data.
- b_valid  in  1  requester B has a write pending.
- b_ready  out  1  B's write is accepted this cycle.
- b_addr  in  ADDR_W  B destination register.
- b_data  in  DATA_W  B write data.
- halt_clr  in  1  leave HALTED state.
- RegWrite  out  1  write strobe to the register bank.
- write_register  out  ADDR_W  bank write address.
- write_data  out  DATA_W  bank write data.
- halted  out  1  program-done write committed.
- wr_count  out  CNT_W  committed writes, saturating.

Behaviour:
- Reset (asynchronous, active-high):
  - RegWrite=0, write_register=0, write_data=0, halted=0, wr_count=0.
  - FSM=RUN; last_grant=B, so A wins the first tie.
  - A write accepted but not yet output is dropped.
- FSM states:
  - RUN -> HALTED at the edge that accepts a write with addr==HALT_REG and data[0]==1.
  - HALTED -> RUN on halt_clr=1.
  - halt_clr in RUN has no effect.
- Ready generation:
  - Combinational from valids, last_grant and FSM.
  - In RUN, exactly one of a_ready/b_ready is high when any valid is high.
  - Only one valid: that requester is granted.
  - Both valid: the requester not granted last is granted.
  - In HALTED, a_ready=b_ready=0.
- Ready never asserts without the matching valid. Requesters hold valid/addr/data stable until ready is seen.
- Acceptance (valid & ready at the edge):
  - write_register/write_data load the granted request.
  - RegWrite=1 for the next cycle only.
  - last_grant updates to the granted requester.
  - Latency: accept edge -> RegWrite high for exactly one cycle after that edge.
- No back-pressure from the bank, so one write can be accepted every cycle with no bubbles.
- With no acceptance, RegWrite=0; write_register/write_data hold their last values.
- Same-address conflict (both valid, same addr):
  - Serialised by round-robin; the loser commits one cycle later, so its data is final in the bank.
  - No merging or dropping.
- r0 is an ordinary register; writes to addr 0 are passed through unchanged.
- Halting write:
  - halted rises at the same edge RegWrite rises for that write, so the r30 write still reaches the bank.
  - Grants stop from the following cycle.
- wr_count increments once per acceptance and saturates at all-ones.
- halt_clr in the same cycle as HALTED entry: the halt entry wins; a second halt_clr is needed.
- reset asserted mid-write forces RegWrite low immediately, with no glitch pulse after release.

Decomposition:
- Shared package:
  - DATA_W, ADDR_W and HALT_REG constants, shared with the register bank.
  - FSM state typedef {RUN, HALTED}.
  - Grant encoding constants GRANT_A/GRANT_B.
- One natural sub-module: rr_arb2 (two-input round-robin arbiter with last_grant register, producing the grant vector).

Test Plan:
- Reset released, a_valid=1 a_addr=5 a_data=0x1234 -> a_ready=1 that cycle; next cycle RegWrite=1, write_register=5, write_data=0x1234, wr_count=1.
- a_valid=b_valid=1 held 4 cycles, A addr 3 data 0xA, B addr 4 data 0xB -> grants A,B,A,B; RegWrite high 4 consecutive cycles; wr_count=4.
- Both valid addr=7, A data=0x11, B data=0x22 after a prior A grant -> B commits first, A second; final write_data=0x11 on the second pulse.
- a_valid addr=30 data=0x1, b_valid pending -> RegWrite pulse to r30, halted=1; b_ready stays 0 until halt_clr, then B granted the next cycle.
- reset pulsed asynchronously mid-cycle right after an acceptance -> RegWrite, halted and wr_count drop to 0 before the next edge; no write is issued.
- wr_count preloaded near max through 0xFFFF+2 acceptances -> wr_count holds 0xFFFF.
